rgb_to_yuv_encoder: RTL and testbench
=====================================

Name: rgb_to_yuv_encoder

Overview:
Colour-space encoder: the write-side counterpart of the YUV-to-RGB decoder. It reads packed RGB pixels from external SRAM and converts each pixel to YUV (BT.601 studio range). It downsamples U/V 2:1 horizontally and writes the Y, U and V planes back into the same SRAM segments the decoder consumes. It sits on the shared SRAM port behind the top-level arbiter and is started by a one-cycle Enable pulse.

Parameters:
Y_BASE, 18'd0, Y plane base word address
U_BASE, 18'd38400, U plane base word address
V_BASE, 18'd57600, V plane base word address
RGB_BASE, 18'd146944, RGB source base word address
PIXEL_COUNT, 76800, pixels per frame (320x240); must be a multiple of 4

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  reset: synchronous, active-low
Enable  in  1  start pulse; sampled in S_IDLE only
SRAM_address  out  18  word address
SRAM_read_data  in  16  read data, valid 2 clocks after the address is presented with SRAM_we_n=1
SRAM_write_data  out  16  write data
SRAM_we_n  out  1  0 = write this cycle, 1 = read
Done  out  1  one-cycle pulse after the last V write

Behaviour:
- Reset (Resetn=0 at a rising edge), all registered:
  - SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, Done=0
  - state=S_IDLE; group counter g=0
- Reset mid-frame aborts immediately. No further writes; partial planes are left as-is.
- Packing, high byte first:
  - RGB words per pixel pair: {R0,G0}, {B0,R1}, {G1,B1}
  - Y word {Y[2k],Y[2k+1]}
  - U word {U'[2m],U'[2m+1]}, where U'[j]=(U[2j]+U[2j+1]+1)>>1 on clipped 8-bit values; V likewise.
- Conversion, signed 32-bit, coefficients scaled by 2^16, >>> is arithmetic:
  - Y=((16843R+33030G+6423B+32768)>>>16)+16
  - U=((-9699R-19071G+28770B+32768)>>>16)+128
  - V=((28770R-24117G-4653B+32768)>>>16)+128
  - Each result is clipped to [0,255].
- Processing is in groups g=0..PIXEL_COUNT/4-1 of 4 pixels (6 RGB words). Each group takes a fixed 12-cycle schedule, states S_G0..S_G11:
  - S_G0..S_G5: SRAM_we_n=1, address RGB_BASE+6g+k for k=0..5. Words return in S_G2..S_G7.
  - S_G6, S_G7: no access (we_n=1, address held); capture the last words.
  - S_G8: write {Y0,Y1} to Y_BASE+2g.
  - S_G9: write {Y2,Y3} to Y_BASE+2g+1.
  - S_G10: write {U'a,U'b} to U_BASE+g.
  - S_G11: write {V'a,V'b} to V_BASE+g. Then g++ and go to S_G0, or to S_DONE if g was last.
- Pixel p's result must be registered before its first write cycle. At most one pixel is converted per cycle.
- S_DONE: Done=1 for exactly one cycle, we_n=1, then S_IDLE.
- Frame latency: Enable seen in S_IDLE → first read address in the next cycle. Total = 12*PIXEL_COUNT/4 + 2 cycles (230402 at defaults).
- Enable asserted outside S_IDLE is ignored. Enable held high in S_IDLE after Done starts a new frame.
- No address wraps: the largest addresses are RGB_BASE+3*PIXEL_COUNT/2-1, Y_BASE+PIXEL_COUNT/2-1, U_BASE+PIXEL_COUNT/4-1 and V_BASE+PIXEL_COUNT/4-1.

Decomposition:
- Shared package/header (the one holding the decoder's state enum):
  - rgb_to_yuv_state_type enum (S_IDLE, S_G0..S_G11, S_DONE)
  - plane base-address constants
  - CSC coefficient constants (shared with the decoder's)
- One sub-module, rgb2yuv_pixel: registered one-cycle single-pixel converter. Inputs R,G,B (8-bit); outputs clipped Y,U,V (8-bit).

Test Plan:
- All RGB words 16'hFFFF, PIXEL_COUNT=8 → Y words 16'hEBEB, U/V words 16'h8080; Done pulses once at cycle 26 after Enable.
- All RGB words 16'h0000 → Y 16'h1010, U 16'h8080, V 16'h8080.
- Pixels 0,1 pure red (255,0,0), pixels 2,3 white → Y words 16'h5252 and 16'hEBEB; U word 16'h5A80; V word 16'hF080.
- Pixel 0 red, pixel 1 black, pixels 2,3 black → U'0=(90+128+1)>>1=109 → U word 16'h6D80; V'0=(240+128+1)>>1=184 → V word 16'hB880.
- Full default frame with a random RGB image → every written word matches the reference model, and no write lands outside the four plane ranges.
- Resetn=0 during S_G9 of group 5 → next cycle SRAM_we_n=1, state S_IDLE; no writes until the next Enable, after which output restarts from g=0.

Source files
------------

// File: rtl/rgb_to_yuv_encoder_pkg.sv
// rgb_to_yuv_encoder_pkg: shared state enum, plane bases, CSC coefficients and helpers
package rgb_to_yuv_encoder_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_G0, S_G1, S_G2, S_G3, S_G4, S_G5, S_G6,
    S_G7, S_G8, S_G9, S_G10, S_G11, S_DONE
  } rgb_to_yuv_state_type;
  localparam logic [17:0] DEF_Y_BASE   = 18'd0;
  localparam logic [17:0] DEF_U_BASE   = 18'd38400;
  localparam logic [17:0] DEF_V_BASE   = 18'd57600;
  localparam logic [17:0] DEF_RGB_BASE = 18'd146944;
  localparam int DEF_PIXEL_COUNT = 76800;
  localparam int signed C_YR = 16843;
  localparam int signed C_YG = 33030;
  localparam int signed C_YB = 6423;
  localparam int signed C_UR = -9699;
  localparam int signed C_UG = -19071;
  localparam int signed C_UB = 28770;
  localparam int signed C_VR = 28770;
  localparam int signed C_VG = -24117;
  localparam int signed C_VB = -4653;
  // Saturate a signed intermediate to an 8-bit component
  function automatic logic [7:0] clip8(input logic signed [31:0] x);
    return x < 0 ? 8'd0 : x > 255 ? 8'd255 : x[7:0];
  endfunction
  // Rounded mean of two neighbouring chroma samples
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = 9'(a) + 9'(b) + 9'd1;
    return s[8:1];
  endfunction
endpackage

// File: rtl/rgb_to_yuv_encoder_if.sv
// rgb_to_yuv_encoder_if: start/done handshake plus the shared SRAM port
interface rgb_to_yuv_encoder_if;
  logic        Enable;
  logic        Done;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  modport master (
    input  Enable, SRAM_read_data,
    output Done, SRAM_address, SRAM_write_data, SRAM_we_n
  );
  modport slave (
    output Enable, SRAM_read_data,
    input  Done, SRAM_address, SRAM_write_data, SRAM_we_n
  );
endinterface

// File: rtl/rgb_to_yuv_encoder_pixel.sv
// rgb2yuv_pixel: registered one-cycle BT.601 studio-range RGB to YUV converter
module rgb2yuv_pixel
  import rgb_to_yuv_encoder_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic [7:0] o_y,
  output logic [7:0] o_u,
  output logic [7:0] o_v
);
  logic signed [31:0] w_r, w_g, w_b;
  assign w_r = {24'd0, i_r};
  assign w_g = {24'd0, i_g};
  assign w_b = {24'd0, i_b};
  // Fixed-point matrix multiply, rounded, offset and clipped in one stage
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      o_y <= 8'd0;
      o_u <= 8'd0;
      o_v <= 8'd0;
    end else begin
      o_y <= clip8(((C_YR * w_r + C_YG * w_g + C_YB * w_b + 32768) >>> 16) + 16);
      o_u <= clip8(((C_UR * w_r + C_UG * w_g + C_UB * w_b + 32768) >>> 16) + 128);
      o_v <= clip8(((C_VR * w_r + C_VG * w_g + C_VB * w_b + 32768) >>> 16) + 128);
    end
  end
endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// rgb_to_yuv_encoder: reads packed RGB from SRAM, writes Y plane and 2:1 downsampled U/V planes
module rgb_to_yuv_encoder
  import rgb_to_yuv_encoder_pkg::*;
#(
  parameter logic [17:0] Y_BASE      = DEF_Y_BASE,
  parameter logic [17:0] U_BASE      = DEF_U_BASE,
  parameter logic [17:0] V_BASE      = DEF_V_BASE,
  parameter logic [17:0] RGB_BASE    = DEF_RGB_BASE,
  parameter int          PIXEL_COUNT = DEF_PIXEL_COUNT
)(
  input logic Clock,
  input logic Resetn,
  rgb_to_yuv_encoder_if.master bus
);
  localparam logic [17:0] G_LAST = 18'(PIXEL_COUNT / 4 - 1);
  rgb_to_yuv_state_type r_state;
  logic [17:0] r_g;
  logic [15:0] r_prev;
  logic [7:0]  r_y [4];
  logic [7:0]  r_u [4];
  logic [7:0]  r_v [4];
  logic        w_odd;
  logic [7:0]  w_r, w_gr, w_b, w_y, w_u, w_v;
  // Odd pixels of a pair straddle words {B0,R1},{G1,B1}; even ones {R0,G0},{B0,R1}
  assign w_odd = r_state == S_G4 || r_state == S_G7;
  assign w_r   = w_odd ? r_prev[7:0] : r_prev[15:8];
  assign w_gr  = w_odd ? bus.SRAM_read_data[15:8] : r_prev[7:0];
  assign w_b   = w_odd ? bus.SRAM_read_data[7:0] : bus.SRAM_read_data[15:8];
  rgb2yuv_pixel u_pixel (
    .Clock  (Clock),
    .Resetn (Resetn),
    .i_r    (w_r),
    .i_g    (w_gr),
    .i_b    (w_b),
    .o_y    (w_y),
    .o_u    (w_u),
    .o_v    (w_v)
  );
  // Group FSM: six reads, two drain cycles, four plane writes; outputs registered per state
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state             <= S_IDLE;
      r_g                 <= 18'd0;
      bus.SRAM_address    <= 18'd0;
      bus.SRAM_write_data <= 16'd0;
      bus.SRAM_we_n       <= 1'b1;
      bus.Done            <= 1'b0;
    end else begin
      r_prev <= bus.SRAM_read_data;
      case (r_state)
        S_IDLE: if (bus.Enable) begin
          r_state          <= S_G0;
          bus.SRAM_address <= RGB_BASE + 18'd6 * r_g;
        end
        S_G0, S_G1, S_G2, S_G3: begin
          r_state          <= rgb_to_yuv_state_type'(r_state + 4'd1);
          bus.SRAM_address <= bus.SRAM_address + 18'd1;
        end
        S_G4: begin
          r_state          <= S_G5;
          bus.SRAM_address <= bus.SRAM_address + 18'd1;
          r_y[0] <= w_y;
          r_u[0] <= w_u;
          r_v[0] <= w_v;
        end
        S_G5: begin
          r_state <= S_G6;
          r_y[1]  <= w_y;
          r_u[1]  <= w_u;
          r_v[1]  <= w_v;
        end
        S_G6: r_state <= S_G7;
        S_G7: begin
          r_state             <= S_G8;
          r_y[2]              <= w_y;
          r_u[2]              <= w_u;
          r_v[2]              <= w_v;
          bus.SRAM_we_n       <= 1'b0;
          bus.SRAM_address    <= Y_BASE + {r_g[16:0], 1'b0};
          bus.SRAM_write_data <= {r_y[0], r_y[1]};
        end
        S_G8: begin
          r_state             <= S_G9;
          r_y[3]              <= w_y;
          r_u[3]              <= w_u;
          r_v[3]              <= w_v;
          bus.SRAM_address    <= Y_BASE + {r_g[16:0], 1'b1};
          bus.SRAM_write_data <= {r_y[2], w_y};
        end
        S_G9: begin
          r_state             <= S_G10;
          bus.SRAM_address    <= U_BASE + r_g;
          bus.SRAM_write_data <= {avg8(r_u[0], r_u[1]), avg8(r_u[2], r_u[3])};
        end
        S_G10: begin
          r_state             <= S_G11;
          bus.SRAM_address    <= V_BASE + r_g;
          bus.SRAM_write_data <= {avg8(r_v[0], r_v[1]), avg8(r_v[2], r_v[3])};
        end
        S_G11: begin
          bus.SRAM_we_n <= 1'b1;
          if (r_g == G_LAST) begin
            r_state  <= S_DONE;
            bus.Done <= 1'b1;
          end else begin
            r_state          <= S_G0;
            r_g              <= r_g + 18'd1;
            bus.SRAM_address <= RGB_BASE + 18'd6 * (r_g + 18'd1);
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_g      <= 18'd0;
          bus.Done <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// tb_rgb_to_yuv_encoder: directed and random frames against a pixel-level reference model
module tb_rgb_to_yuv_encoder;
  localparam int PC = 32, G = PC / 4, LIM = 12 * G + 40;
  localparam int YB = 0, UB = 38400, VB = 57600, RB = 146944;
  typedef struct {int a; logic [15:0] d;} wr_t;
  logic clk = 1'b0, rstn = 1'b0;
  int errs = 0, checks = 0;
  logic [15:0] mem [int];
  logic [15:0] p1;
  wr_t wlog [$];
  int pr [PC], pg [PC], pb [PC], ey [PC], eu [PC], ev [PC];
  always #5 clk = ~clk;
  rgb_to_yuv_encoder_if bus ();
  rgb_to_yuv_encoder #(.PIXEL_COUNT(PC)) dut (.Clock(clk), .Resetn(rstn), .bus(bus));
  // SRAM with two-cycle read latency; writes are logged in order
  always @(posedge clk) begin
    p1 <= mem.exists(int'(bus.SRAM_address)) ? mem[int'(bus.SRAM_address)] : 16'h0;
    bus.SRAM_read_data <= p1;
    if (!bus.SRAM_we_n) wlog.push_back(wr_t'{int'(bus.SRAM_address), bus.SRAM_write_data});
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int clip(int x);
    return x < 0 ? 0 : x > 255 ? 255 : x;
  endfunction
  function automatic logic [15:0] word_at(int a, int start);
    logic [15:0] w = 16'hxxxx;
    for (int i = start; i < wlog.size(); i++) if (wlog[i].a == a) w = wlog[i].d;
    return w;
  endfunction
  task automatic load_image();
    for (int i = 0; i < PC; i++) begin
      ey[i] = clip(((16843 * pr[i] + 33030 * pg[i] + 6423 * pb[i] + 32768) >>> 16) + 16);
      eu[i] = clip(((-9699 * pr[i] - 19071 * pg[i] + 28770 * pb[i] + 32768) >>> 16) + 128);
      ev[i] = clip(((28770 * pr[i] - 24117 * pg[i] - 4653 * pb[i] + 32768) >>> 16) + 128);
    end
    for (int k = 0; k < PC / 2; k++) begin
      mem[RB + 3 * k]     = {8'(pr[2 * k]), 8'(pg[2 * k])};
      mem[RB + 3 * k + 1] = {8'(pb[2 * k]), 8'(pr[2 * k + 1])};
      mem[RB + 3 * k + 2] = {8'(pg[2 * k + 1]), 8'(pb[2 * k + 1])};
    end
  endtask
  task automatic set_pixel(int i, int r, int g, int b);
    pr[i] = r;
    pg[i] = g;
    pb[i] = b;
  endtask
  task automatic run_frame(input bit poke, output int start);
    int n = 0;
    start = wlog.size();
    bus.Enable = 1'b1;
    tick();
    bus.Enable = 1'b0;
    while (!bus.Done && n < LIM) begin
      if (poke) bus.Enable = (n == 30);
      tick();
      n++;
    end
    bus.Enable = 1'b0;
    checks++;
    if (n !== 12 * G) $display("FAIL done_latency: got %0d edges, want %0d", n, 12 * G);
    if (n !== 12 * G) errs++;
    tick();
    checks++;
    if (bus.Done !== 1'b0) begin errs++; $display("FAIL done_width: Done=%b, want 0", bus.Done); end
  endtask
  task automatic check_planes(input int start);
    int oob = 0;
    logic [15:0] got, exp;
    for (int i = start; i < wlog.size(); i++)
      if (!((wlog[i].a >= YB && wlog[i].a < YB + PC / 2) || (wlog[i].a >= UB && wlog[i].a < UB + G) ||
            (wlog[i].a >= VB && wlog[i].a < VB + G))) oob++;
    checks++;
    if (wlog.size() - start !== 4 * G) begin errs++; $display("FAIL write_count: got %0d, want %0d", wlog.size() - start, 4 * G); end
    checks++;
    if (oob !== 0) begin errs++; $display("FAIL out_of_range_writes: got %0d, want 0", oob); end
    for (int k = 0; k < PC / 2; k++) begin
      got = word_at(YB + k, start);
      exp = {8'(ey[2 * k]), 8'(ey[2 * k + 1])};
      checks++;
      if (got !== exp) begin errs++; $display("FAIL y_word[%0d]: got %h, want %h", k, got, exp); end
    end
    for (int m = 0; m < G; m++) begin
      got = word_at(UB + m, start);
      exp = {8'((eu[4 * m] + eu[4 * m + 1] + 1) >> 1), 8'((eu[4 * m + 2] + eu[4 * m + 3] + 1) >> 1)};
      checks++;
      if (got !== exp) begin errs++; $display("FAIL u_word[%0d]: got %h, want %h", m, got, exp); end
      got = word_at(VB + m, start);
      exp = {8'((ev[4 * m] + ev[4 * m + 1] + 1) >> 1), 8'((ev[4 * m + 2] + ev[4 * m + 3] + 1) >> 1)};
      checks++;
      if (got !== exp) begin errs++; $display("FAIL v_word[%0d]: got %h, want %h", m, got, exp); end
    end
  endtask
  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    checks += 4;
    if (bus.SRAM_we_n !== 1'b1) begin errs++; $display("FAIL reset_we_n: got %b, want 1", bus.SRAM_we_n); end
    if (bus.SRAM_address !== 18'd0) begin errs++; $display("FAIL reset_addr: got %h, want 0", bus.SRAM_address); end
    if (bus.SRAM_write_data !== 16'd0) begin errs++; $display("FAIL reset_wdata: got %h, want 0", bus.SRAM_write_data); end
    if (bus.Done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b, want 0", bus.Done); end
    rstn = 1'b1;
    tick();
  endtask
  task automatic test_solid(input int v, input logic [15:0] ywant);
    int s;
    for (int i = 0; i < PC; i++) set_pixel(i, v, v, v);
    load_image();
    run_frame(1'b0, s);
    check_planes(s);
    checks += 3;
    if (word_at(YB, s) !== ywant) begin errs++; $display("FAIL solid_y: got %h, want %h", word_at(YB, s), ywant); end
    if (word_at(UB, s) !== 16'h8080) begin errs++; $display("FAIL solid_u: got %h, want 8080", word_at(UB, s)); end
    if (word_at(VB, s) !== 16'h8080) begin errs++; $display("FAIL solid_v: got %h, want 8080", word_at(VB, s)); end
  endtask
  task automatic test_red_white();
    int s;
    for (int i = 0; i < PC; i++) if (i % 4 < 2) set_pixel(i, 255, 0, 0); else set_pixel(i, 255, 255, 255);
    load_image();
    run_frame(1'b0, s);
    check_planes(s);
    checks += 4;
    if (word_at(YB, s) !== 16'h5252) begin errs++; $display("FAIL rw_y0: got %h, want 5252", word_at(YB, s)); end
    if (word_at(YB + 1, s) !== 16'hEBEB) begin errs++; $display("FAIL rw_y1: got %h, want ebeb", word_at(YB + 1, s)); end
    if (word_at(UB, s) !== 16'h5A80) begin errs++; $display("FAIL rw_u: got %h, want 5a80", word_at(UB, s)); end
    if (word_at(VB, s) !== 16'hF080) begin errs++; $display("FAIL rw_v: got %h, want f080", word_at(VB, s)); end
  endtask
  task automatic test_red_black();
    int s;
    for (int i = 0; i < PC; i++) if (i % 4 == 0) set_pixel(i, 255, 0, 0); else set_pixel(i, 0, 0, 0);
    load_image();
    run_frame(1'b0, s);
    check_planes(s);
    checks += 2;
    if (word_at(UB, s) !== 16'h6D80) begin errs++; $display("FAIL rb_u: got %h, want 6d80", word_at(UB, s)); end
    if (word_at(VB, s) !== 16'hB880) begin errs++; $display("FAIL rb_v: got %h, want b880", word_at(VB, s)); end
  endtask
  task automatic test_random();
    int s;
    for (int i = 0; i < PC; i++) set_pixel(i, $urandom_range(255), $urandom_range(255), $urandom_range(255));
    load_image();
    run_frame(1'b1, s);
    check_planes(s);
  endtask
  task automatic test_reset_mid();
    int s, s2;
    for (int i = 0; i < PC; i++) set_pixel(i, $urandom_range(255), $urandom_range(255), $urandom_range(255));
    load_image();
    s = wlog.size();
    bus.Enable = 1'b1;
    tick();
    bus.Enable = 1'b0;
    repeat (12 * 5 + 9) tick();
    rstn = 1'b0;
    tick();
    checks += 3;
    if (bus.SRAM_we_n !== 1'b1) begin errs++; $display("FAIL mid_reset_we_n: got %b, want 1", bus.SRAM_we_n); end
    if (bus.SRAM_address !== 18'd0) begin errs++; $display("FAIL mid_reset_addr: got %h, want 0", bus.SRAM_address); end
    if (wlog.size() - s !== 22) begin errs++; $display("FAIL mid_reset_writes: got %0d, want 22", wlog.size() - s); end
    rstn = 1'b1;
    repeat (30) tick();
    checks++;
    if (wlog.size() - s !== 22) begin errs++; $display("FAIL idle_after_reset: got %0d writes, want 22", wlog.size() - s); end
    run_frame(1'b0, s2);
    checks++;
    if (wlog.size() <= s2 || wlog[s2].a !== YB) begin errs++; $display("FAIL restart_first_write: want address %0d", YB); end
    check_planes(s2);
  endtask
  task automatic test_back_to_back();
    int n = 0, s;
    for (int i = 0; i < PC; i++) set_pixel(i, $urandom_range(255), $urandom_range(255), $urandom_range(255));
    load_image();
    bus.Enable = 1'b1;
    tick();
    while (!bus.Done && n < LIM) begin tick(); n++; end
    s = wlog.size();
    tick();
    tick();
    checks += 2;
    if (bus.SRAM_address !== 18'(RB)) begin errs++; $display("FAIL b2b_restart_addr: got %h, want %h", bus.SRAM_address, 18'(RB)); end
    if (bus.SRAM_we_n !== 1'b1) begin errs++; $display("FAIL b2b_restart_we_n: got %b, want 1", bus.SRAM_we_n); end
    bus.Enable = 1'b0;
    n = 2;
    while (!bus.Done && n < LIM) begin tick(); n++; end
    checks++;
    if (n !== 12 * G + 2) begin errs++; $display("FAIL b2b_period: got %0d, want %0d", n, 12 * G + 2); end
    tick();
    check_planes(s);
  endtask
  initial begin
    bus.Enable = 1'b0;
    test_reset();
    test_solid(255, 16'hEBEB);
    test_solid(0, 16'h1010);
    test_red_white();
    test_red_black();
    test_random();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
